// File: rtl/mem_arbiter.sv
// Two-master Wishbone arbiter for the shared memory port: master 0 (MEMC) has fixed
// priority, master 1 is protected by a starvation counter, and a watchdog turns a hung slave into an error.
module mem_arbiter #(
    parameter int MAX_WAIT = 64,
    parameter int TIMEOUT  = 255
) (
    input  logic        clkcpu,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [23:2] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [23:2] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [23:2] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [2:0]  s_cti_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ERR = 2'd3} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [7:0] TO_LAST_C  = 8'(TIMEOUT - 1);

    state_t     state_r, state_s;
    logic [7:0] wait_cnt_r, wait_cnt_s;
    logic [7:0] to_cnt_r, to_cnt_s;
    logic [1:0] err_r, err_s;
    logic [1:0] gnt_r;
    logic       err_sel_r, err_sel_s;
    logic       own_cyc_s, own_stb_s, timeout_s;

    function automatic logic [1:0] gnt_of(input state_t st);
        case (st)
            GNT0:    gnt_of = 2'b01;
            GNT1:    gnt_of = 2'b10;
            default: gnt_of = 2'b00;
        endcase
    endfunction

    // Owner handshake and slave-side mux; IDLE and ERR park the slave at all-zero
    always_comb begin
        own_cyc_s = 1'b0;
        own_stb_s = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = 22'd0;
        s_sel_o   = 4'd0;
        s_cti_o   = 3'd0;
        s_dat_o   = 32'd0;
        case (state_r)
            GNT0: begin
                own_cyc_s = m0_cyc_i;
                own_stb_s = m0_stb_i;
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_adr_o   = m0_adr_i;
                s_sel_o   = m0_sel_i;
                s_cti_o   = m0_cti_i;
                s_dat_o   = m0_dat_i;
            end
            GNT1: begin
                own_cyc_s = m1_cyc_i;
                own_stb_s = m1_stb_i;
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_adr_o   = m1_adr_i;
                s_sel_o   = m1_sel_i;
                s_cti_o   = m1_cti_i;
                s_dat_o   = m1_dat_i;
            end
            default: begin
                own_cyc_s = 1'b0;
            end
        endcase
    end

    // An ack in the last watchdog cycle wins over the timeout
    assign timeout_s = own_stb_s & ~s_ack_i & (to_cnt_r == TO_LAST_C);

    // Arbitration, watchdog and starvation-counter next values
    always_comb begin
        state_s    = state_r;
        err_s      = 2'b00;
        err_sel_s  = err_sel_r;
        to_cnt_s   = 8'd0;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            IDLE: begin
                if (m1_cyc_i && (wait_cnt_r >= MAX_WAIT_C)) begin
                    state_s = GNT1;
                end else if (m0_cyc_i) begin
                    state_s = GNT0;
                end else if (m1_cyc_i) begin
                    state_s = GNT1;
                end else begin
                    state_s = IDLE;
                end
            end
            GNT0, GNT1: begin
                if (!own_cyc_s) begin
                    state_s = IDLE;
                end else if (timeout_s) begin
                    state_s   = ERR;
                    err_s     = (state_r == GNT0) ? 2'b01 : 2'b10;
                    err_sel_s = (state_r == GNT1);
                end else begin
                    state_s = state_r;
                end
            end
            ERR: begin
                if (err_sel_r ? !m1_cyc_i : !m0_cyc_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = ERR;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if ((state_s == state_r) && own_stb_s && !s_ack_i) begin
            to_cnt_s = to_cnt_r + 8'd1;
        end else begin
            to_cnt_s = 8'd0;
        end

        if (!m1_cyc_i) begin
            wait_cnt_s = 8'd0;
        end else if ((state_s == GNT1) && (state_r != GNT1)) begin
            wait_cnt_s = 8'd0;
        end else if ((state_r != GNT1) && (wait_cnt_r != 8'd255)) begin
            wait_cnt_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_s = wait_cnt_r;
        end
    end

    // State, counters, error pulse and grant registers
    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            state_r    <= IDLE;
            wait_cnt_r <= 8'd0;
            to_cnt_r   <= 8'd0;
            err_r      <= 2'b00;
            err_sel_r  <= 1'b0;
            gnt_r      <= 2'b00;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            to_cnt_r   <= to_cnt_s;
            err_r      <= err_s;
            err_sel_r  <= err_sel_s;
            gnt_r      <= gnt_of(state_s);
        end
    end

    assign m0_ack_o  = (state_r == GNT0) & s_ack_i;
    assign m1_ack_o  = (state_r == GNT1) & s_ack_i;
    assign m0_err_o  = err_r[0];
    assign m1_err_o  = err_r[1];
    assign m0_rdat_o = s_dat_i;
    assign m1_rdat_o = s_dat_i;
    assign gnt_o     = gnt_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter: a behavioural model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_mem_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [23:2] adr [2];
    logic [3:0]  sel [2];
    logic [2:0]  cti [2];
    logic [31:0] dat [2];
    logic        s_ack_i = 1'b0;
    logic [31:0] s_dat_i = 32'd0;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [23:2] s_adr_o;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic [31:0] s_dat_o;
    logic [1:0]  gnt_o;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clkcpu(clk), .rst_i(rst_i),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
        .m0_sel_i(sel[0]), .m0_cti_i(cti[0]), .m0_dat_i(dat[0]),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rdat_o(m0_rdat),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
        .m1_sel_i(sel[1]), .m1_cti_i(cti[1]), .m1_dat_i(dat[1]),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdat_o(m1_rdat),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = 22'd0;
            sel[i] = 4'd0; cti[i] = 3'd0; dat[i] = 32'd0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, req);
        end
    endtask

    // ---------------- slave model: programmable ack latency or hang ----------------
    int lat_min = 1, lat_max = 1, cur_lat = 1, lat_cnt = 0;
    bit slave_hang = 1'b0;

    always begin
        @(posedge clk);
        #2;
        if (s_cyc_o && s_stb_o && !slave_hang) begin
            if (lat_cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
            lat_cnt++;
            if (lat_cnt >= cur_lat) begin
                s_ack_i = 1'b1;
                lat_cnt = 0;
            end else begin
                s_ack_i = 1'b0;
            end
        end else begin
            s_ack_i = 1'b0;
            lat_cnt = 0;
        end
        s_dat_i = $urandom;
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [1:0]  gnt;
        logic [2:0]  ctl;
        logic [21:0] adr;
        logic [6:0]  selcti;
        logic [31:0] dat;
        logic [3:0]  ackerr;
        logic [31:0] rdat;
        logic [7:0]  wcnt;
    } exp_t;
    exp_t exp_q[$];

    int owner = -1;          // -1: nobody owns the slave
    bit errored = 1'b0;      // waiting for the errored master to drop cyc
    int err_m = 0;
    int wait_m = 0, to_m = 0;
    logic [1:0] errp = 2'b00;
    int n_owner, n_to;
    bit n_err;
    logic [1:0] n_errp;
    exp_t e_new;

    always begin
        @(posedge clk);
        if (rst_i) begin
            owner = -1; errored = 1'b0; wait_m = 0; to_m = 0; errp = 2'b00;
        end else begin
            n_owner = owner; n_err = errored; n_to = 0; n_errp = 2'b00;
            if (errored) begin
                if (!cyc[err_m]) n_err = 1'b0;
            end else if (owner < 0) begin
                if (cyc[1] && wait_m >= MAX_WAIT) n_owner = 1;
                else if (cyc[0]) n_owner = 0;
                else if (cyc[1]) n_owner = 1;
            end else if (!cyc[owner]) begin
                n_owner = -1;
            end else if (stb[owner] && !s_ack_i) begin
                if (to_m == TIMEOUT - 1) begin
                    n_owner = -1; n_err = 1'b1; err_m = owner; n_errp[owner] = 1'b1;
                end else begin
                    n_to = to_m + 1;
                end
            end
            if (!cyc[1]) wait_m = 0;
            else if (n_owner == 1 && owner != 1) wait_m = 0;
            else if (owner != 1 && wait_m < 255) wait_m = wait_m + 1;
            owner = n_owner; errored = n_err; to_m = n_to; errp = n_errp;
        end
        #3;
        e_new.gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        if (owner >= 0) begin
            e_new.ctl    = {cyc[owner], stb[owner], we[owner]};
            e_new.adr    = adr[owner];
            e_new.selcti = {sel[owner], cti[owner]};
            e_new.dat    = dat[owner];
        end else begin
            e_new.ctl = 3'd0; e_new.adr = 22'd0; e_new.selcti = 7'd0; e_new.dat = 32'd0;
        end
        e_new.ackerr = {errp[1], errp[0], (owner == 1) && s_ack_i, (owner == 0) && s_ack_i};
        e_new.rdat   = s_dat_i;
        e_new.wcnt   = 8'(wait_m);
        exp_q.push_back(e_new);
    end

    exp_t e_got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_got = exp_q.pop_front();
            chk("gnt", 64'(gnt_o), 64'(e_got.gnt));
            chk("slave_ctl", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'(e_got.ctl));
            chk("slave_adr", 64'(s_adr_o), 64'(e_got.adr));
            chk("slave_sel_cti", 64'({s_sel_o, s_cti_o}), 64'(e_got.selcti));
            chk("slave_dat", 64'(s_dat_o), 64'(e_got.dat));
            chk("ack_err", 64'({m1_err, m0_err, m1_ack, m0_ack}), 64'(e_got.ackerr));
            chk("rdat", 64'({m1_rdat, m0_rdat}), 64'({e_got.rdat, e_got.rdat}));
            chk("wait_cnt", 64'(dut.wait_cnt_r), 64'(e_got.wcnt));
        end
    end

    // ---------------- master driver ----------------
    task automatic m_burst(input int m, input int beats, input int gap);
        bit got_err = 1'b0;
        bit done;
        cyc[m] = 1'b1;
        for (int b = 0; b < beats && !got_err; b++) begin
            stb[m] = 1'b1;
            we[m]  = 1'($urandom_range(1, 0));
            adr[m] = 22'($urandom);
            sel[m] = 4'($urandom);
            dat[m] = $urandom;
            cti[m] = (beats == 1) ? 3'b000 : (b == beats - 1) ? 3'b111 : 3'b010;
            done = 1'b0;
            for (int t = 0; t < 400 && !done; t++) begin
                @(negedge clk);
                done    = (m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
                got_err = (m == 0) ? m0_err : m1_err;
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL m%0d_ack_wait: actual no ack or err, required one within 400 cycles", m);
                got_err = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cyc[m] = 1'b0; stb[m] = 1'b0; cti[m] = 3'd0; we[m] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // ---------------- directed and random phases ----------------
    bit seen_gnt1;
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // single transfer, three-cycle slave
        lat_min = 3; lat_max = 3;
        m_burst(0, 1, 2);

        // simultaneous requests
        lat_min = 1; lat_max = 2;
        fork
            m_burst(0, 1, 1);
            m_burst(1, 1, 1);
        join

        // back-to-back bursts from master 0 against a persistent master 1
        fork
            begin
                for (int k = 0; k < 6; k++) m_burst(0, 4, 1);
            end
            begin
                m_burst(1, 1, 1);
                m_burst(1, 2, 1);
            end
        join

        // hung slave: watchdog error, then master 0 releases
        slave_hang = 1'b1;
        m_burst(0, 1, 3);
        slave_hang = 1'b0;

        // ack exactly on the watchdog's last cycle
        lat_min = TIMEOUT; lat_max = TIMEOUT;
        m_burst(0, 2, 2);
        lat_min = TIMEOUT - 1; lat_max = TIMEOUT - 1;
        m_burst(1, 2, 2);

        // reset in the middle of a master 1 burst
        lat_min = 4; lat_max = 4;
        fork
            m_burst(1, 4, 2);
            begin
                seen_gnt1 = 1'b0;
                for (int t = 0; t < 100 && !seen_gnt1; t++) begin
                    @(negedge clk);
                    seen_gnt1 = (gnt_o == 2'b10);
                end
                checks++;
                if (!seen_gnt1) begin
                    errors++;
                    $display("FAIL gnt1_wait: actual no grant to master 1, required one within 100 cycles");
                end
                repeat (5) @(posedge clk);
                #1 rst_i = 1'b1;
                @(posedge clk);
                #1 rst_i = 1'b0;
            end
        join

        // random traffic from both masters
        lat_min = 1; lat_max = 5;
        fork
            begin
                for (int k = 0; k < 40; k++)
                    m_burst(0, $urandom_range(4, 1), $urandom_range(4, 1));
            end
            begin
                for (int k = 0; k < 40; k++)
                    m_burst(1, $urandom_range(4, 1), $urandom_range(4, 1));
            end
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: actual still running, required finish before 800000");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master Wishbone arbiter that shares the single external memory port (SDRAM controller side) between MEMC and one auxiliary bus master, such as a future podule or IDE DMA engine. Master 0 (MEMC, which carries CPU, video and sound DMA) has fixed priority. Master 1 is protected from starvation by a wait counter. A per-transfer watchdog turns a hung slave into a Wishbone error instead of a system lockup.

## Interface
Parameters:
- MAX_WAIT, 64: cycles master 1 may wait while requesting before it wins over master 0 (range 1–255).
- TIMEOUT, 255: cycles a granted strobe may go without ack before an error is forced (range 2–255).

Ports:
- clkcpu  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (MEMC) cycle, strobe and write enable.
- m0_adr_i  in  [23:2]  master 0 word address.
- m0_sel_i  in  4  master 0 byte selects.
- m0_cti_i  in  3  master 0 cycle type (010 = burst, 111 = end of burst).
- m0_dat_i  in  32  master 0 write data.
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge and error.
- m1_*: the same nine signals for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave (memory) cycle, strobe and write enable.
- s_adr_o  out  [23:2]  slave word address.
- s_sel_o  out  4  slave byte selects.
- s_cti_o  out  3  slave cycle type.
- s_dat_o  out  32  slave write data.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  32  slave read data; broadcast unregistered to both masters as m0_rdat_o and m1_rdat_o (out, 32).
- gnt_o  out  2  current owner, one-hot: 01 = master 0, 10 = master 1, 00 = none.

## Operation
- State register states: IDLE, GNT0, GNT1, ERR.
- Slave outputs are combinational muxes from the state register:
  - GNT0 passes through master 0's signals; GNT1 passes through master 1's.
  - IDLE and ERR drive s_cyc_o, s_stb_o and s_we_o to 0, and s_adr_o, s_sel_o, s_cti_o and s_dat_o to 0.
- IDLE transitions, evaluated each edge:
  - m1_cyc_i is high and wait_cnt ≥ MAX_WAIT: go to GNT1.
  - Otherwise m0_cyc_i is high: go to GNT0.
  - Otherwise m1_cyc_i is high: go to GNT1.
  - Otherwise stay in IDLE.
- GNTx:
  - s_ack_i is routed to mx_ack_o only; the other master sees ack = 0 and err = 0.
  - The grant is held while mx_cyc_i stays high, including burst beats (cti 010 through 111). There is no preemption.
  - mx_cyc_i low at an edge: go to IDLE.
- Watchdog (to_cnt, 8 bits):
  - Cleared on entering GNTx, on s_ack_i, and whenever stb is low.
  - Increments each GNTx cycle with stb high and no ack.
  - When to_cnt = TIMEOUT-1 with no ack: next state is ERR and mx_err_o pulses for exactly that one cycle (registered).
- ERR: the slave is idle and the errored master's ack and err are 0. Stay in ERR until that master's cyc is low, then go to IDLE.
- Starvation counter (wait_cnt, 8 bits):
  - Increments each cycle m1_cyc_i is high and the state is not GNT1.
  - Saturates at 255.
  - Cleared on entry to GNT1 and whenever m1_cyc_i is low.
- mx_ack_o is combinational from s_ack_i, so slave latency is preserved with no added cycle.

## Timing
- Reset (synchronous):
  - State returns to IDLE; wait_cnt, to_cnt, the err flops and gnt_o are 0.
  - All slave outputs and all master ack/err outputs are 0 in the cycle after the reset edge.
  - Reset mid-transfer abandons the transfer silently; no err is issued.
- Grant latency: cyc sampled at edge N gives the state GNTx after edge N, and s_cyc_o and s_stb_o are high during cycle N+1.
- Release: master drops cyc before edge M, the state is IDLE in cycle M+1, and the new owner reaches the slave in cycle M+2. This gives at least one dead slave cycle between owners.
- Simultaneous requests from IDLE: master 0 wins unless the starvation threshold is met.
- An ack and the timeout edge in the same cycle: the ack wins and to_cnt clears.
- gnt_o is registered and decoded directly from the state: ERR gives 00.

## Test plan
- Reset, then idle: all outputs are 0 and gnt_o = 00. Assert m0_cyc/stb with a 3-cycle-latency slave -> s_cyc rises 1 cycle after the request; m0_ack pulses once; m1_ack stays 0.
- Both masters request in the same cycle -> GNT0 first. When m0 drops cyc, gnt_o goes 00 for one cycle, then 10.
- Master 0 runs back-to-back 4-beat bursts (cti 010, 010, 010, 111) while master 1 requests continuously, MAX_WAIT = 8 -> no burst is split. Master 1 is granted on the first arbitration after wait_cnt reaches 8, and wait_cnt then reads 0.
- Slave never acks, TIMEOUT = 16 -> m0_err pulses exactly once, 16 cycles after stb rose. The slave then idles and the state stays ERR until m0 drops cyc, then returns to IDLE.
- Assert rst_i for one cycle in the middle of a GNT1 burst -> the next cycle has all slave outputs 0, no ack or err on either master, and wait_cnt = 0.
- Ack arriving on the cycle the timeout would fire (cycle 15 with TIMEOUT = 16) -> normal ack, no err, transfer continues.
